bus_arbiter_nm: RTL and testbench

//  Parametrised N-master shared-bus arbiter and slave decoder for the SoC memory bus.

---
 rtl/bus_arbiter_nm.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter_nm.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_nm.sv
// N-master shared-bus arbiter with slave chip-select decode.
// Arbitration is fixed priority (master 0 highest) or round-robin. One command
// is accepted at a time, driven onto the shared bus for LATENCY cycles, and
// answered with a registered one-cycle response pulse to the granted master.
//
// Handshake: a master raises m_req with its command fields stable. The command
// is taken on the edge that raises m_gnt for one cycle. After that edge the
// master may drop m_req or change its fields. Exactly one m_rsp_valid pulse
// follows each grant, LATENCY+1 cycles after m_gnt. m_rdata and m_rsp_err are
// meaningful only in that cycle. A request still high after its response is
// treated as a new request.
module bus_arbiter_nm #(
    parameter int N_MASTERS = 3,
    parameter int N_SLAVES  = 3,
    parameter int ADR_W     = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_LO    = 16,
    parameter int SEL_W     = 2,
    parameter int LATENCY   = 1,
    parameter int RR_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*ADR_W-1:0]    m_adr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wren,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic [N_MASTERS-1:0]          m_rsp_valid,
    output logic                          m_rsp_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          bus_op,
    output logic [ADR_W-1:0]              bus_adr,
    output logic [DATA_W-1:0]             bus_di,
    output logic [DATA_W/8-1:0]           bus_wren,
    output logic [N_SLAVES-1:0]           bus_cs,
    input  logic [DATA_W-1:0]             bus_do
);

    localparam int MIDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // FSM state is a plain named signal so that checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [MIDX_W-1:0] win;
    logic [MIDX_W-1:0] cand;
    logic [MIDX_W-1:0] g_q;
    logic [MIDX_W-1:0] rr_ptr;
    logic              any_req;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   wren_q;
    logic [3:0]        count;
    logic              err_q;
    logic [SEL_W-1:0]  sel;
    logic              mapped;

    assign sel    = adr_q[SEL_LO +: SEL_W];
    assign mapped = (int'(sel) < N_SLAVES);

    // Winner selection: lowest index in fixed mode, first requester after the
    // round-robin pointer otherwise. Loops run from the far end so the last
    // assignment is the preferred candidate.
    always_comb begin
        win     = '0;
        cand    = '0;
        any_req = |m_req;
        if (RR_MODE != 0) begin
            for (int i = N_MASTERS; i >= 1; i--) begin
                cand = MIDX_W'((int'(rr_ptr) + i) % N_MASTERS);
                if (m_req[cand]) win = cand;
            end
        end else begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                cand = MIDX_W'(i);
                if (m_req[cand]) win = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (count == 4'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, access counter, response registers and RR pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q         <= '0;
            rr_ptr      <= MIDX_W'(N_MASTERS - 1);
            adr_q       <= '0;
            wdata_q     <= '0;
            wren_q      <= '0;
            count       <= '0;
            err_q       <= 1'b0;
            m_gnt       <= '0;
            m_rsp_valid <= '0;
            m_rsp_err   <= 1'b0;
            m_rdata     <= '0;
        end else begin
            m_gnt       <= '0;
            m_rsp_valid <= '0;
            m_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g_q     <= win;
                        adr_q   <= m_adr[int'(win)*ADR_W +: ADR_W];
                        wdata_q <= m_wdata[int'(win)*DATA_W +: DATA_W];
                        wren_q  <= m_wren[int'(win)*BE_W +: BE_W];
                        m_gnt   <= N_MASTERS'(1) << win;
                        count   <= 4'(LATENCY);
                    end
                end
                ACCESS: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        m_rdata <= mapped ? bus_do : '0;
                        err_q   <= !mapped;
                    end
                end
                RESP: begin
                    m_rsp_valid <= N_MASTERS'(1) << g_q;
                    m_rsp_err   <= err_q;
                    rr_ptr      <= g_q;
                end
                default: ;
            endcase
        end
    end

    // Shared bus drive: only during ACCESS; byte enables only in the first
    // access cycle and never towards an unmapped slave.
    always_comb begin
        bus_op   = (state == ACCESS);
        bus_adr  = bus_op ? adr_q : '0;
        bus_di   = bus_op ? wdata_q : '0;
        bus_cs   = (bus_op && mapped) ? (N_SLAVES'(1) << sel) : '0;
        bus_wren = (bus_op && mapped && count == 4'(LATENCY)) ? wren_q : '0;
    end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench for bus_arbiter_nm. Four instances share the master-side
// inputs and reset: fixed L=1 (with a small RAM model), RR L=1, fixed L=3,
// and RR L=4. Inputs change and outputs are sampled on the falling edge.
module tb_bus_arbiter_nm;

    localparam int NM = 3;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NM-1:0]      m_req;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM*BW-1:0]   m_wren;

    logic [NM-1:0]      gnt   [4];
    logic [NM-1:0]      rsp   [4];
    logic               err   [4];
    logic [DW-1:0]      rdata [4];
    logic               op    [4];
    logic [AW-1:0]      badr  [4];
    logic [DW-1:0]      bdi   [4];
    logic [BW-1:0]      bwren [4];
    logic [NS-1:0]      cs    [4];
    logic [DW-1:0]      bdo   [4];

    logic [DW-1:0]      mem [16] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    // Clock generation.
    always #5 clk = ~clk;

    bus_arbiter_nm #(.RR_MODE(0), .LATENCY(1)) dut_fix (
        .clk(clk), .reset(reset), .m_req(m_req), .m_adr(m_adr), .m_wdata(m_wdata), .m_wren(m_wren),
        .m_gnt(gnt[0]), .m_rsp_valid(rsp[0]), .m_rsp_err(err[0]), .m_rdata(rdata[0]),
        .bus_op(op[0]), .bus_adr(badr[0]), .bus_di(bdi[0]), .bus_wren(bwren[0]), .bus_cs(cs[0]), .bus_do(bdo[0]));

    bus_arbiter_nm #(.RR_MODE(1), .LATENCY(1)) dut_rr (
        .clk(clk), .reset(reset), .m_req(m_req), .m_adr(m_adr), .m_wdata(m_wdata), .m_wren(m_wren),
        .m_gnt(gnt[1]), .m_rsp_valid(rsp[1]), .m_rsp_err(err[1]), .m_rdata(rdata[1]),
        .bus_op(op[1]), .bus_adr(badr[1]), .bus_di(bdi[1]), .bus_wren(bwren[1]), .bus_cs(cs[1]), .bus_do(bdo[1]));

    bus_arbiter_nm #(.RR_MODE(0), .LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .m_req(m_req), .m_adr(m_adr), .m_wdata(m_wdata), .m_wren(m_wren),
        .m_gnt(gnt[2]), .m_rsp_valid(rsp[2]), .m_rsp_err(err[2]), .m_rdata(rdata[2]),
        .bus_op(op[2]), .bus_adr(badr[2]), .bus_di(bdi[2]), .bus_wren(bwren[2]), .bus_cs(cs[2]), .bus_do(bdo[2]));

    bus_arbiter_nm #(.RR_MODE(1), .LATENCY(4)) dut_l4 (
        .clk(clk), .reset(reset), .m_req(m_req), .m_adr(m_adr), .m_wdata(m_wdata), .m_wren(m_wren),
        .m_gnt(gnt[3]), .m_rsp_valid(rsp[3]), .m_rsp_err(err[3]), .m_rdata(rdata[3]),
        .bus_op(op[3]), .bus_adr(badr[3]), .bus_di(bdi[3]), .bus_wren(bwren[3]), .bus_cs(cs[3]), .bus_do(bdo[3]));

    // Slave models: RAM on slave 0 for dut_fix, inverted address for dut_l3.
    assign bdo[0] = (cs[0] != '0) ? mem[badr[0][5:2]] : '0;
    assign bdo[1] = '0;
    assign bdo[2] = (cs[2] != '0) ? ~badr[2] : '0;
    assign bdo[3] = '0;

    // Byte-enabled RAM write for dut_fix slave 0.
    always @(posedge clk) begin
        for (int b = 0; b < BW; b++)
            if (cs[0][0] && bwren[0][b]) mem[badr[0][5:2]][b*8 +: 8] <= bdi[0][b*8 +: 8];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] w);
        m_adr[i*AW +: AW]   = a;
        m_wdata[i*DW +: DW] = d;
        m_wren[i*BW +: BW]  = w;
    endtask

    task automatic do_reset();
        m_req = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({gnt[k], rsp[k], err[k], op[k], cs[k], bwren[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got gnt=%b rsp=%b err=%b op=%b cs=%b wren=%b want all 0",
                         k, gnt[k], rsp[k], err[k], op[k], cs[k], bwren[k]);
            end
            n_checks++;
            if ({rdata[k], badr[k], bdi[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got rdata=%h adr=%h di=%h want 0", k, rdata[k], badr[k], bdi[k]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [NM-1:0] eg, er;
        do_reset();
        set_master(0, 32'h0000_0000, '0, '0);
        set_master(1, 32'h0000_0004, '0, '0);
        set_master(2, 32'h0000_0008, '0, '0);
        m_req = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            tick();
            eg = (c % 3 == 1) ? 3'b001 : 3'b000;
            er = (c % 3 == 0) ? 3'b001 : 3'b000;
            n_checks++;
            if (gnt[0] !== eg) begin
                n_fail++;
                $display("FAIL fixed_gnt c%0d: got %b want %b", c, gnt[0], eg);
            end
            n_checks++;
            if (rsp[0] !== er) begin
                n_fail++;
                $display("FAIL fixed_rsp c%0d: got %b want %b", c, rsp[0], er);
            end
        end
        m_req = '0;
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] eg, er;
        do_reset();
        m_req = 3'b111;
        for (int c = 1; c <= 18; c++) begin
            tick();
            eg = (c % 3 == 1) ? 3'(1 << ((c / 3) % 3)) : 3'b000;
            er = (c % 3 == 0) ? 3'(1 << (((c - 3) / 3) % 3)) : 3'b000;
            n_checks++;
            if (gnt[1] !== eg) begin
                n_fail++;
                $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt[1], eg);
            end
            n_checks++;
            if (rsp[1] !== er) begin
                n_fail++;
                $display("FAIL rr_rsp c%0d: got %b want %b", c, rsp[1], er);
            end
        end
        m_req = '0;
    endtask

    task automatic test_write_read();
        do_reset();
        set_master(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011);
        m_req = 3'b010;
        tick();
        n_checks++;
        if ({gnt[0], op[0], cs[0], bwren[0]} !== {3'b010, 1'b1, 3'b001, 4'b0011}) begin
            n_fail++;
            $display("FAIL wr_access: got gnt=%b op=%b cs=%b wren=%b want 010 1 001 0011", gnt[0], op[0], cs[0], bwren[0]);
        end
        n_checks++;
        if ({badr[0], bdi[0]} !== {32'h0000_0010, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL wr_bus: got adr=%h di=%h want 00000010 deadbeef", badr[0], bdi[0]);
        end
        m_req = '0;
        tick();
        n_checks++;
        if ({op[0], bwren[0]} !== '0) begin
            n_fail++;
            $display("FAIL wr_resp_idle: got op=%b wren=%b want 0", op[0], bwren[0]);
        end
        tick();
        n_checks++;
        if ({rsp[0], err[0]} !== {3'b010, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_rsp: got rsp=%b err=%b want 010 0", rsp[0], err[0]);
        end
        set_master(1, 32'h0000_0010, '0, 4'b0000);
        m_req = 3'b010;
        tick();
        n_checks++;
        if ({gnt[0], cs[0], bwren[0]} !== {3'b010, 3'b001, 4'b0000}) begin
            n_fail++;
            $display("FAIL rd_access: got gnt=%b cs=%b wren=%b want 010 001 0000", gnt[0], cs[0], bwren[0]);
        end
        m_req = '0;
        tick();
        tick();
        n_checks++;
        if ({rsp[0], rdata[0]} !== {3'b010, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL rd_rsp: got rsp=%b rdata=%h want 010 0000beef", rsp[0], rdata[0]);
        end
    endtask

    task automatic test_latency3();
        logic [NS-1:0] ecs;
        logic [BW-1:0] ewr;
        logic [NM-1:0] er;
        do_reset();
        set_master(0, 32'h0002_0004, 32'h1234_5678, 4'b0000);
        m_req = 3'b001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ecs = ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) ? 3'b100 : 3'b000;
            ewr = (c == 6) ? 4'b1111 : 4'b0000;
            er  = (c == 5 || c == 10) ? 3'b001 : 3'b000;
            n_checks++;
            if ({cs[2], op[2], bwren[2]} !== {ecs, (ecs != '0), ewr}) begin
                n_fail++;
                $display("FAIL l3_bus c%0d: got cs=%b op=%b wren=%b want cs=%b wren=%b", c, cs[2], op[2], bwren[2], ecs, ewr);
            end
            n_checks++;
            if (rsp[2] !== er) begin
                n_fail++;
                $display("FAIL l3_rsp c%0d: got %b want %b", c, rsp[2], er);
            end
            if (c == 1 || c == 6) m_req = '0;
            if (c == 5) begin
                n_checks++;
                if (rdata[2] !== 32'hFFFD_FFFB) begin
                    n_fail++;
                    $display("FAIL l3_rdata: got %h want fffdfffb", rdata[2]);
                end
                set_master(0, 32'h0002_0004, 32'h1234_5678, 4'b1111);
                m_req = 3'b001;
            end
        end
    endtask

    task automatic test_unmapped();
        do_reset();
        set_master(0, 32'h0000_0010, '0, 4'b0000);
        m_req = 3'b001;
        tick();
        m_req = '0;
        tick();
        tick();
        n_checks++;
        if ({rsp[0], err[0], rdata[0]} !== {3'b001, 1'b0, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL um_pre: got rsp=%b err=%b rdata=%h want 001 0 0000beef", rsp[0], err[0], rdata[0]);
        end
        set_master(2, 32'h0003_0000, 32'hFFFF_FFFF, 4'b1111);
        m_req = 3'b100;
        tick();
        n_checks++;
        if ({gnt[0], op[0], cs[0], bwren[0]} !== {3'b100, 1'b1, 3'b000, 4'b0000}) begin
            n_fail++;
            $display("FAIL um_access: got gnt=%b op=%b cs=%b wren=%b want 100 1 000 0000", gnt[0], op[0], cs[0], bwren[0]);
        end
        m_req = '0;
        tick();
        tick();
        n_checks++;
        if ({rsp[0], err[0], rdata[0]} !== {3'b100, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL um_rsp: got rsp=%b err=%b rdata=%h want 100 1 0", rsp[0], err[0], rdata[0]);
        end
        tick();
        n_checks++;
        if ({rsp[0], err[0]} !== '0) begin
            n_fail++;
            $display("FAIL um_after: got rsp=%b err=%b want 0 0", rsp[0], err[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [NM-1:0] er;
        do_reset();
        for (int i = 0; i < NM; i++) set_master(i, 32'h0001_0000, '0, '0);
        m_req = 3'b001;
        tick();
        m_req = '0;
        for (int c = 2; c <= 6; c++) tick();
        n_checks++;
        if (rsp[3] !== 3'b001) begin
            n_fail++;
            $display("FAIL rm_first_rsp: got %b want 001", rsp[3]);
        end
        m_req = 3'b111;
        tick();
        n_checks++;
        if (gnt[3] !== 3'b010) begin
            n_fail++;
            $display("FAIL rm_rr_gnt: got %b want 010", gnt[3]);
        end
        tick();
        n_checks++;
        if ({op[3], cs[3]} !== {1'b1, 3'b010}) begin
            n_fail++;
            $display("FAIL rm_access: got op=%b cs=%b want 1 010", op[3], cs[3]);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({op[3], cs[3], bwren[3], gnt[3], rsp[3]} !== '0) begin
            n_fail++;
            $display("FAIL rm_abort: got op=%b cs=%b wren=%b gnt=%b rsp=%b want 0",
                     op[3], cs[3], bwren[3], gnt[3], rsp[3]);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (gnt[3] !== 3'b001) begin
            n_fail++;
            $display("FAIL rm_restart_gnt: got %b want 001", gnt[3]);
        end
        m_req = '0;
        for (int c = 11; c <= 15; c++) begin
            tick();
            er = (c == 15) ? 3'b001 : 3'b000;
            n_checks++;
            if (rsp[3] !== er) begin
                n_fail++;
                $display("FAIL rm_rsp c%0d: got %b want %b", c, rsp[3], er);
            end
        end
    endtask

    // Watchdog: the sequence below is fixed-length, this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Test sequence and summary.
    initial begin
        reset   = 1'b1;
        m_req   = '0;
        m_adr   = '0;
        m_wdata = '0;
        m_wren  = '0;
        tick();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_write_read();
        test_latency3();
        test_unmapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
